// File: rtl/trace_capture_ctrl.sv
// trace_capture_ctrl: sequences capture of per-cycle trace words into an
// external single-port trace RAM. The RAM holds a circular pre-trigger
// history, the trigger word, then a fixed post-trigger window.
//
// Optional feature macro: TRACE_CTRL_TRIG_MASK_EN
//   defined   -> adds trig_mask_i; trigger when ((pc ^ trig_pc_i) & trig_mask_i) == 0
//   undefined -> trigger on exact 64-bit PC equality
//
// Ports:
//   clk_i, rst_ni          clock, async active-low reset
//   capture_i              trace word from the capture register
//   capture_valid_i        capture_i holds a retired-instruction record
//   arm_i                  pulse; start a new capture run
//   stop_i                 pulse; abort the run and freeze the buffer
//   trig_pc_i              trigger PC value
//   trig_mask_i            trigger compare mask (macro builds only)
//   post_count_i           words written after the trigger word
//   buf_we_o/addr_o/wdata_o  registered RAM write port
//   state_o                0 IDLE, 1 PRE, 2 POST, 3 DONE
//   wrapped_o              write pointer wrapped in this run
//   trig_addr_o            RAM address holding the trigger word
//   done_o                 high while in DONE
module trace_capture_ctrl #(
  parameter int unsigned WIDTH  = 1230,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned AW     = 8,
  parameter int unsigned PC_LSB = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] capture_i,
  input  logic             capture_valid_i,
  input  logic             arm_i,
  input  logic             stop_i,
  input  logic [63:0]      trig_pc_i,
`ifdef TRACE_CTRL_TRIG_MASK_EN
  input  logic [63:0]      trig_mask_i,
`endif
  input  logic [AW-1:0]    post_count_i,
  output logic             buf_we_o,
  output logic [AW-1:0]    buf_addr_o,
  output logic [WIDTH-1:0] buf_wdata_o,
  output logic [1:0]       state_o,
  output logic             wrapped_o,
  output logic [AW-1:0]    trig_addr_o,
  output logic             done_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_POST = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_e             state_q, state_d;
  logic [AW-1:0]      wptr_q, wptr_d;
  logic [AW-1:0]      post_cnt_q, post_cnt_d;
  logic               wrapped_q, wrapped_d;
  logic [AW-1:0]      trig_addr_q, trig_addr_d;
  logic               we_q, we_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [WIDTH-1:0]   wdata_q, wdata_d;
  logic               done_q, done_d;

  logic [63:0]        pc;
  logic               trig_hit;
  logic               accept;

  // Trigger compare on the PC field of the incoming word
  assign pc = capture_i[PC_LSB +: 64];
`ifdef TRACE_CTRL_TRIG_MASK_EN
  assign trig_hit = (((pc ^ trig_pc_i) & trig_mask_i) == 64'd0);
`else
  assign trig_hit = (pc == trig_pc_i);
`endif

  // Next-state, write path and bookkeeping
  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    post_cnt_d  = post_cnt_q;
    wrapped_d   = wrapped_q;
    trig_addr_d = trig_addr_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    accept      = 1'b0;

    case (state_q)
      // stop is ignored here, so arm wins in DONE
      ST_IDLE, ST_DONE: begin
        if (arm_i) begin
          state_d     = ST_PRE;
          wptr_d      = '0;
          wrapped_d   = 1'b0;
          trig_addr_d = '0;
        end
      end
      ST_PRE: begin
        if (stop_i) begin
          state_d = ST_DONE;
        end else if (capture_valid_i) begin
          accept = 1'b1;
          if (trig_hit) begin
            trig_addr_d = wptr_q;
            post_cnt_d  = post_count_i;
            state_d     = (post_count_i == '0) ? ST_DONE : ST_POST;
          end
        end
      end
      ST_POST: begin
        if (stop_i) begin
          state_d = ST_DONE;
        end else if (capture_valid_i) begin
          accept     = 1'b1;
          post_cnt_d = post_cnt_q - AW'(1);
          if (post_cnt_q == AW'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Accepted word is written next cycle at the current pointer
    if (accept) begin
      we_d    = 1'b1;
      addr_d  = wptr_q;
      wdata_d = capture_i;
      wptr_d  = wptr_q + AW'(1);
      if (wptr_q == LAST_ADDR) begin
        wrapped_d = 1'b1;
      end
    end
  end

  assign done_d = (state_d == ST_DONE);

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      wptr_q      <= '0;
      post_cnt_q  <= '0;
      wrapped_q   <= 1'b0;
      trig_addr_q <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      post_cnt_q  <= post_cnt_d;
      wrapped_q   <= wrapped_d;
      trig_addr_q <= trig_addr_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      done_q      <= done_d;
    end
  end

  assign buf_we_o    = we_q;
  assign buf_addr_o  = addr_q;
  assign buf_wdata_o = wdata_q;
  assign state_o     = state_q;
  assign wrapped_o   = wrapped_q;
  assign trig_addr_o = trig_addr_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_trace_capture_ctrl.sv
// Testbench for trace_capture_ctrl (DEPTH=16). Expected RAM writes are
// queued when a word is driven and popped by a write monitor.
module tb_trace_capture_ctrl;

  localparam int unsigned W     = 1230;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  capture;
  logic          capture_valid;
  logic          arm;
  logic          stop;
  logic [63:0]   trig_pc;
  logic [63:0]   trig_mask;
  logic [AW-1:0] post_count;
  logic          buf_we;
  logic [AW-1:0] buf_addr;
  logic [W-1:0]  buf_wdata;
  logic [1:0]    state;
  logic          wrapped;
  logic [AW-1:0] trig_addr;
  logic          done;

  int checks;
  int failures;
  int wr_cnt;

  logic [AW-1:0] exp_addr_q[$];
  logic [W-1:0]  exp_data_q[$];

  trace_capture_ctrl #(
    .WIDTH (W),
    .DEPTH (DEPTH),
    .AW    (AW),
    .PC_LSB(0)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .capture_i      (capture),
    .capture_valid_i(capture_valid),
    .arm_i          (arm),
    .stop_i         (stop),
    .trig_pc_i      (trig_pc),
`ifdef TRACE_CTRL_TRIG_MASK_EN
    .trig_mask_i    (trig_mask),
`endif
    .post_count_i   (post_count),
    .buf_we_o       (buf_we),
    .buf_addr_o     (buf_addr),
    .buf_wdata_o    (buf_wdata),
    .state_o        (state),
    .wrapped_o      (wrapped),
    .trig_addr_o    (trig_addr),
    .done_o         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitor: every RAM write must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n && buf_we) begin
      wr_cnt++;
      checks++;
      if (exp_addr_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write addr=%0d", buf_addr);
      end else begin
        logic [AW-1:0] ea;
        logic [W-1:0]  ed;
        ea = exp_addr_q.pop_front();
        ed = exp_data_q.pop_front();
        if (buf_addr !== ea || buf_wdata !== ed) begin
          failures++;
          $display("FAIL write_payload addr=%0d exp_addr=%0d data_ok=%0b",
                   buf_addr, ea, (buf_wdata === ed));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  function automatic logic [W-1:0] mk(input logic [63:0] pc, input logic [31:0] tag);
    logic [W-1:0] w;
    w = '0;
    w[63:0]       = pc;
    w[600 +: 32]  = ~tag;
    w[W-1 -: 32]  = tag;
    return w;
  endfunction

  // One clock of stimulus; optionally queue the expected write
  task automatic drive(input logic v, input logic [W-1:0] w, input logic a,
                       input logic s, input logic exp_wr, input logic [AW-1:0] ea);
    capture_valid = v;
    capture       = w;
    arm           = a;
    stop          = s;
    if (exp_wr) begin
      exp_addr_q.push_back(ea);
      exp_data_q.push_back(w);
    end
    @(posedge clk);
    #1;
    capture_valid = 1'b0;
    arm           = 1'b0;
    stop          = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_addr_q.size() != 0) begin
      failures++;
      $display("FAIL %s_missing_writes pending=%0d required=0", name, exp_addr_q.size());
      exp_addr_q.delete();
      exp_data_q.delete();
    end
  endtask

  task automatic test_reset;
    checks++;
    if (state !== 2'd0 || buf_we !== 1'b0 || wrapped !== 1'b0 || done !== 1'b0 ||
        buf_addr !== '0 || trig_addr !== '0 || buf_wdata !== '0) begin
      failures++;
      $display("FAIL reset_values state=%0d we=%0b wrapped=%0b done=%0b addr=%0d trig=%0d",
               state, buf_we, wrapped, done, buf_addr, trig_addr);
    end
    // Valid words in IDLE are not written
    drive(1'b1, mk(64'h100, 32'h1), 1'b0, 1'b0, 1'b0, '0);
    idle(1);
    checks++;
    if (state !== 2'd0) begin
      failures++;
      $display("FAIL idle_hold state=%0d required=0", state);
    end
  endtask

  task automatic test_basic;
    trig_pc    = 64'h8000_0040;
    post_count = 4'd2;
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
    checks++;
    if (state !== 2'd1) begin
      failures++;
      $display("FAIL basic_arm state=%0d required=1", state);
    end
    wr_cnt = 0;
    for (int i = 0; i < 3; i++)
      drive(1'b1, mk(64'h100 + 64'(4 * i), 32'hA0 + 32'(i)), 1'b0, 1'b0, 1'b1, AW'(i));
    drive(1'b1, mk(64'h8000_0040, 32'hA3), 1'b0, 1'b0, 1'b1, 4'd3);
    checks++;
    if (state !== 2'd2 || trig_addr !== 4'd3) begin
      failures++;
      $display("FAIL basic_trigger state=%0d trig_addr=%0d required=2/3", state, trig_addr);
    end
    drive(1'b1, mk(64'h200, 32'hA4), 1'b0, 1'b0, 1'b1, 4'd4);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL basic_early_done done=%0b required=0", done);
    end
    drive(1'b1, mk(64'h204, 32'hA5), 1'b0, 1'b0, 1'b1, 4'd5);
    checks++;
    if (done !== 1'b1 || state !== 2'd3) begin
      failures++;
      $display("FAIL basic_done done=%0b state=%0d required=1/3", done, state);
    end
    // Extra valid words in DONE are not written
    drive(1'b1, mk(64'h208, 32'hA6), 1'b0, 1'b0, 1'b0, '0);
    idle(1);
    check_drained("basic");
    checks++;
    if (wr_cnt != 6 || buf_addr !== 4'd5 || wrapped !== 1'b0) begin
      failures++;
      $display("FAIL basic_totals writes=%0d addr=%0d wrapped=%0b required=6/5/0",
               wr_cnt, buf_addr, wrapped);
    end
  endtask

  task automatic test_wrap;
    trig_pc    = 64'h2000;
    post_count = 4'd0;
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 20; i++)
      drive(1'b1, mk(64'h300 + 64'(4 * i), 32'hB00 + 32'(i)), 1'b0, 1'b0, 1'b1, AW'(i % 16));
    checks++;
    if (wrapped !== 1'b1 || state !== 2'd1) begin
      failures++;
      $display("FAIL wrap_flag wrapped=%0b state=%0d required=1/1", wrapped, state);
    end
    drive(1'b1, mk(64'h2000, 32'hBFF), 1'b0, 1'b0, 1'b1, 4'd4);
    checks++;
    if (done !== 1'b1 || trig_addr !== 4'd4 || wrapped !== 1'b1) begin
      failures++;
      $display("FAIL wrap_trigger done=%0b trig_addr=%0d wrapped=%0b required=1/4/1",
               done, trig_addr, wrapped);
    end
    idle(2);
    check_drained("wrap");
    checks++;
    if (buf_addr !== 4'd4 || buf_we !== 1'b0) begin
      failures++;
      $display("FAIL wrap_last_addr addr=%0d we=%0b required=4/0", buf_addr, buf_we);
    end
  endtask

  task automatic test_gaps;
    trig_pc    = 64'h4000;
    post_count = 4'd2;
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
    checks++;
    if (wrapped !== 1'b0 || trig_addr !== 4'd0) begin
      failures++;
      $display("FAIL gaps_arm_clear wrapped=%0b trig_addr=%0d required=0/0", wrapped, trig_addr);
    end
    drive(1'b1, mk(64'h4000, 32'hC0), 1'b0, 1'b0, 1'b1, 4'd0);
    idle(1);
    wr_cnt = 0;
    drive(1'b1, mk(64'h4004, 32'hC1), 1'b0, 1'b0, 1'b1, 4'd1);
    drive(1'b0, mk(64'h4008, 32'hC2), 1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, mk(64'h400C, 32'hC3), 1'b0, 1'b0, 1'b0, '0);
    checks++;
    if (state !== 2'd2) begin
      failures++;
      $display("FAIL gaps_hold state=%0d required=2", state);
    end
    drive(1'b1, mk(64'h4010, 32'hC4), 1'b0, 1'b0, 1'b1, 4'd2);
    checks++;
    if (state !== 2'd3) begin
      failures++;
      $display("FAIL gaps_done state=%0d required=3", state);
    end
    idle(1);
    check_drained("gaps");
    checks++;
    if (wr_cnt != 2) begin
      failures++;
      $display("FAIL gaps_writes writes=%0d required=2", wr_cnt);
    end
  endtask

  task automatic test_stop_priority;
    trig_pc    = 64'h5000;
    post_count = 4'd3;
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
    drive(1'b1, mk(64'h5000, 32'hD0), 1'b0, 1'b0, 1'b1, 4'd0);
    drive(1'b1, mk(64'h5004, 32'hD1), 1'b1, 1'b1, 1'b0, '0);
    checks++;
    if (state !== 2'd3 || done !== 1'b1) begin
      failures++;
      $display("FAIL stop_priority state=%0d done=%0b required=3/1", state, done);
    end
    idle(2);
    check_drained("stop");
    checks++;
    if (state !== 2'd3 || buf_addr !== 4'd0) begin
      failures++;
      $display("FAIL stop_no_restart state=%0d addr=%0d required=3/0", state, buf_addr);
    end
    // In DONE, arm wins over stop
    drive(1'b0, '0, 1'b1, 1'b1, 1'b0, '0);
    checks++;
    if (state !== 2'd1 || done !== 1'b0) begin
      failures++;
      $display("FAIL done_arm_stop state=%0d done=%0b required=1/0", state, done);
    end
    drive(1'b1, mk(64'h5008, 32'hD2), 1'b0, 1'b1, 1'b0, '0);
    idle(1);
    check_drained("stop_pre");
    checks++;
    if (state !== 2'd3) begin
      failures++;
      $display("FAIL stop_in_pre state=%0d required=3", state);
    end
  endtask

  task automatic test_trig_mask;
    trig_pc    = 64'h1000;
    trig_mask  = 64'hFFFF_FFFF_FFFF_FF00;
    post_count = 4'd0;
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
    drive(1'b1, mk(64'h10A4, 32'hE0), 1'b0, 1'b0, 1'b1, 4'd0);
`ifdef TRACE_CTRL_TRIG_MASK_EN
    checks++;
    if (state !== 2'd3 || trig_addr !== 4'd0) begin
      failures++;
      $display("FAIL mask_trigger state=%0d trig_addr=%0d required=3/0", state, trig_addr);
    end
    trig_mask = 64'd0;
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
    drive(1'b1, mk(64'h7777, 32'hE1), 1'b0, 1'b0, 1'b1, 4'd0);
    checks++;
    if (state !== 2'd3) begin
      failures++;
      $display("FAIL mask_zero state=%0d required=3", state);
    end
`else
    checks++;
    if (state !== 2'd1) begin
      failures++;
      $display("FAIL exact_no_trigger state=%0d required=1", state);
    end
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
`endif
    trig_mask = '1;
    idle(1);
    check_drained("mask");
  endtask

  task automatic test_reset_mid_post;
    trig_pc    = 64'h6000;
    post_count = 4'd5;
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
    drive(1'b1, mk(64'h6000, 32'hF0), 1'b0, 1'b0, 1'b1, 4'd0);
    drive(1'b1, mk(64'h6004, 32'hF1), 1'b0, 1'b0, 1'b1, 4'd1);
    // This word's write is pending when reset hits; it must vanish
    drive(1'b1, mk(64'h6008, 32'hF2), 1'b0, 1'b0, 1'b0, '0);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (state !== 2'd0 || buf_we !== 1'b0 || wrapped !== 1'b0 || done !== 1'b0 ||
        buf_addr !== '0) begin
      failures++;
      $display("FAIL reset_mid_post state=%0d we=%0b wrapped=%0b done=%0b addr=%0d",
               state, buf_we, wrapped, done, buf_addr);
    end
    #10;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) drive(1'b1, mk(64'h600C, 32'hF3), 1'b0, 1'b0, 1'b0, '0);
    check_drained("reset");
    checks++;
    if (state !== 2'd0 || buf_we !== 1'b0) begin
      failures++;
      $display("FAIL reset_after state=%0d we=%0b required=0/0", state, buf_we);
    end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    wr_cnt        = 0;
    rst_n         = 1'b0;
    capture       = '0;
    capture_valid = 1'b0;
    arm           = 1'b0;
    stop          = 1'b0;
    trig_pc       = '0;
    trig_mask     = '1;
    post_count    = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    rst_n = 1'b1;
    idle(1);
    test_reset;
    test_basic;
    test_wrap;
    test_gaps;
    test_stop_priority;
    test_trig_mask;
    test_reset_mid_post;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trace_capture_ctrl.md
Name: trace_capture_ctrl

Overview:
- Sequences capture of the per-cycle trace word (tracer_t, 1230 bits) into an external single-port trace RAM.
- Provides arm, PC-trigger and post-trigger-count control, so the RAM holds a circular pre-trigger history followed by a fixed post-trigger window.
- Sits between the registered trace capture stage and the trace buffer RAM. Debug/host logic reads the RAM directly once done_o is high.

Parameters:
- WIDTH, 1230, trace word width in bits.
- DEPTH, 256, trace RAM entries; must be a power of two.
- AW, 8, address width; equals log2(DEPTH).
- PC_LSB, 0, bit offset of the 64-bit PC field inside the trace word.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- capture_i  in  WIDTH  trace word from the capture register.
- capture_valid_i  in  1  capture_i holds a retired-instruction record this cycle.
- arm_i  in  1  single-cycle pulse; starts a new capture run.
- stop_i  in  1  single-cycle pulse; aborts the run and freezes the buffer.
- trig_pc_i  in  64  trigger PC value.
- post_count_i  in  AW  number of words to write after the trigger word.
- buf_we_o  out  1  RAM write strobe.
- buf_addr_o  out  AW  RAM write address.
- buf_wdata_o  out  WIDTH  RAM write data.
- state_o  out  2  current state: 0 IDLE, 1 PRE, 2 POST, 3 DONE.
- wrapped_o  out  1  write pointer has wrapped at least once in this run.
- trig_addr_o  out  AW  RAM address that holds the trigger word.
- done_o  out  1  high while in DONE.

Behaviour:
- Reset values: state IDLE; buf_we_o, wrapped_o and done_o 0; buf_addr_o, trig_addr_o and buf_wdata_o all 0. The internal write pointer and post counter reset to 0.
- "Accepted word" = capture_valid_i high in PRE or POST with stop_i low.
- Write path:
  - An accepted word in cycle t gives buf_we_o=1 in cycle t+1, with buf_wdata_o = capture_i(t) and buf_addr_o = wptr(t).
  - wptr then increments modulo DEPTH.
  - Going from DEPTH-1 to 0 sets wrapped_o, which stays set until the next arm.
  - buf_we_o is 0 in every other cycle. buf_addr_o and buf_wdata_o hold their last values when buf_we_o is 0.
- State transitions:
  - IDLE to PRE on arm_i. wptr, wrapped_o and trig_addr_o are cleared. No word is written in the arm cycle.
  - PRE, accepted word with capture_i[PC_LSB+63:PC_LSB] == trig_pc_i: the word is written and trig_addr_o = wptr. The post counter loads post_count_i. Next state is POST, or DONE if post_count_i == 0.
  - PRE, accepted word without a match: written, stay in PRE.
  - POST: each accepted word is written and the counter decrements. The word written when the counter is 1 moves the state to DONE. capture_valid_i low leaves the counter unchanged.
  - DONE: no writes; all outputs hold. arm_i goes to PRE and starts a new run.
- stop_i:
  - In PRE or POST, stop_i moves the state to DONE and the word in that cycle is not written.
  - stop_i is ignored in IDLE and DONE.
  - If arm_i and stop_i are both high in PRE or POST, stop wins.
- arm_i is ignored in PRE and POST.
- In DONE, simultaneous arm_i and stop_i: arm wins, because stop is ignored in DONE.
- post_count_i is sampled only at the trigger. A value greater than DEPTH-1 is impossible by width. A value equal to DEPTH-1 overwrites everything except the trigger word.
- A pending buf_we_o still completes in the cycle after the state enters DONE. It is the registered write of the final accepted word.
- Reset asserted mid-run forces all state and outputs to their reset values immediately; no partial write is issued after reset.

Optional Feature:
- Macro: TRACE_CTRL_TRIG_MASK_EN.
- Defined: adds input trig_mask_i, 64 bits. The trigger matches when ((pc ^ trig_pc_i) & trig_mask_i) == 0. A mask of all zeros triggers on the first accepted word.
- Undefined: no trig_mask_i port; the trigger requires an exact 64-bit equality.

Test Plan:
- Reset: assert rst_ni=0 mid-POST at a cycle with no clock edge -> state_o=0, buf_we_o=0, wrapped_o=0 immediately; no write after release.
- Basic run (DEPTH=16): arm, 3 non-matching words, then PC 0x8000_0040 == trig_pc_i, post_count_i=2, 2 more words -> writes at addr 0..5, trig_addr_o=3, done_o=1 one cycle after the last accept, 6 buf_we_o pulses total.
- Wrap: arm, 20 words without a match, then trigger with post_count_i=0 -> wrapped_o=1, trigger word at addr 4, done_o=1, last write addr 4.
- Stop priority: in POST, stop_i, arm_i and capture_valid_i all high in one cycle -> state DONE, no write for that word, run not restarted.
- Gaps: in POST with counter=2, capture_valid_i toggles 1,0,0,1 -> exactly 2 writes, DONE after the 4th cycle.
- Mask (macro defined): trig_mask_i=0xFFFF_FFFF_FFFF_FF00, trig_pc_i=0x1000, word PC 0x10A4 -> triggers; with macro undefined the same word does not trigger.
